// File: rtl/player_motion_ctrl_pkg.sv
// Shared types and widths for the player motion sequencer.
package player_pkg;

    localparam int POS_W  = 10;
    localparam int VEL_W  = 8;
    localparam int CHG_W  = 6;
    localparam int CALC_W = 12;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WALK     = 3'd1,
        CHARGE   = 3'd2,
        AIRBORNE = 3'd3,
        LAND     = 3'd4
    } state_e;

endpackage

// File: rtl/player_motion_ctrl_if.sv
// Controller-side bundle: per-frame inputs in, sprite position/state out.
interface player_motion_if;

    logic                          frame_tick;
    logic                          left;
    logic                          right;
    logic                          jump;
    logic [player_pkg::POS_W-1:0]  pos_x;
    logic [player_pkg::POS_W-1:0]  pos_y;
    player_pkg::state_e            state;
    logic                          facing;
    logic [player_pkg::CHG_W-1:0]  charge;
    logic                          landed;

    modport master (
        output frame_tick, left, right, jump,
        input  pos_x, pos_y, state, facing, charge, landed
    );

    modport slave (
        input  frame_tick, left, right, jump,
        output pos_x, pos_y, state, facing, charge, landed
    );

endinterface

// File: rtl/player_motion_ctrl_axis_step.sv
// One motion axis: pos + signed vel, clamped to [LO,HI], with out-of-range flags.
module motion_axis_step
    import player_pkg::*;
#(
    parameter int LO = 0,
    parameter int HI = 608
) (
    input  logic [POS_W-1:0]        pos,
    input  logic signed [VEL_W-1:0] vel,
    output logic [POS_W-1:0]        next_pos,
    output logic                    hit_lo,
    output logic                    hit_hi
);

    localparam logic signed [CALC_W-1:0] LO_C = CALC_W'(LO);
    localparam logic signed [CALC_W-1:0] HI_C = CALC_W'(HI);

    logic signed [CALC_W-1:0] sum;

    // Widen before adding so a step past either limit is seen, not wrapped.
    always_comb begin
        sum      = $signed({{(CALC_W-POS_W){1'b0}}, pos})
                 + $signed({{(CALC_W-VEL_W){vel[VEL_W-1]}}, vel});
        hit_lo   = sum < LO_C;
        hit_hi   = sum > HI_C;
        next_pos = hit_lo ? LO_C[POS_W-1:0] :
                   hit_hi ? HI_C[POS_W-1:0] : sum[POS_W-1:0];
    end

endmodule

// File: rtl/player_motion_ctrl.sv
// Per-frame player motion FSM (IDLE/WALK/CHARGE/AIRBORNE/LAND) with velocity integration.
// Define WALL_BOUNCE_EN to reflect vx on wall hits; otherwise a wall hit stops horizontal motion.
module player_motion_ctrl
    import player_pkg::*;
#(
    parameter int X_MIN      = 0,
    parameter int X_MAX      = 608,
    parameter int FLOOR_Y    = 416,
    parameter int Y_MIN      = 0,
    parameter int START_X    = 304,
    parameter int WALK_SPEED = 2,
    parameter int AIR_SPEED  = 3,
    parameter int JUMP_BASE  = 4,
    parameter int MAX_CHARGE = 20,
    parameter int GRAVITY    = 1,
    parameter int MAX_FALL   = 12,
    parameter int LAND_TICKS = 4
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    player_motion_if.slave  bus
);

    localparam logic signed [VEL_W-1:0] WALK_V    = VEL_W'(WALK_SPEED);
    localparam logic signed [VEL_W-1:0] AIR_V     = VEL_W'(AIR_SPEED);
    localparam logic signed [VEL_W-1:0] GRAV_V    = VEL_W'(GRAVITY);
    localparam logic signed [VEL_W-1:0] FALL_V    = VEL_W'(MAX_FALL);
    localparam logic signed [VEL_W-1:0] BASE_V    = VEL_W'(JUMP_BASE);
    localparam logic [CHG_W-1:0]        CHG_MAX   = CHG_W'(MAX_CHARGE);
    localparam logic [2:0]              LAND_LAST = 3'(LAND_TICKS - 1);

    state_e                  state_q, state_d;
    logic [POS_W-1:0]        x_q, x_d, y_q, y_d;
    logic signed [VEL_W-1:0] vx_q, vx_d, vy_q, vy_d;
    logic [CHG_W-1:0]        charge_q, charge_d;
    logic                    facing_q, facing_d;
    logic                    landed_q, landed_d;
    logic [2:0]              land_cnt_q, land_cnt_d;

    logic [POS_W-1:0]        x_next, y_next;
    logic                    x_hit_lo, x_hit_hi, y_hit_lo, y_hit_hi;
    logic signed [VEL_W-1:0] x_vel, vy_inc, launch_vy;
    logic                    one_dir, floor_hit;

    assign one_dir   = bus.left ^ bus.right;
    // The x stepper is shared: walking speed on the ground, vx in the air.
    assign x_vel     = (state_q == AIRBORNE) ? vx_q : (bus.left ? -WALK_V : WALK_V);
    assign vy_inc    = vy_q + GRAV_V;
    assign launch_vy = -(BASE_V + $signed({{(VEL_W-CHG_W){1'b0}}, charge_q}));
    assign floor_hit = !vy_q[VEL_W-1] && (vy_q != '0)
                     && (y_hit_hi || (y_next == POS_W'(FLOOR_Y)));

    motion_axis_step #(.LO(X_MIN), .HI(X_MAX)) u_x_step (
        .pos      (x_q),
        .vel      (x_vel),
        .next_pos (x_next),
        .hit_lo   (x_hit_lo),
        .hit_hi   (x_hit_hi)
    );

    motion_axis_step #(.LO(Y_MIN), .HI(FLOOR_Y)) u_y_step (
        .pos      (y_q),
        .vel      (vy_q),
        .next_pos (y_next),
        .hit_lo   (y_hit_lo),
        .hit_hi   (y_hit_hi)
    );

    always_ff @(posedge sys_clk) begin
        // NOTE: non-blocking so every register samples the pre-edge values.
        if (sys_rst) begin
            state_q    <= IDLE;
            x_q        <= POS_W'(START_X);
            y_q        <= POS_W'(FLOOR_Y);
            vx_q       <= '0;
            vy_q       <= '0;
            charge_q   <= '0;
            facing_q   <= 1'b1;
            landed_q   <= 1'b0;
            land_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            vx_q       <= vx_d;
            vy_q       <= vy_d;
            charge_q   <= charge_d;
            facing_q   <= facing_d;
            landed_q   <= landed_d;
            land_cnt_q <= land_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.frame_tick) begin
            case (state_q)
                IDLE, WALK: begin
                    if (bus.jump)   state_d = CHARGE;
                    else if (one_dir) state_d = WALK;
                    else            state_d = IDLE;
                end
                CHARGE:   if (!bus.jump) state_d = AIRBORNE;
                AIRBORNE: if (floor_hit) state_d = LAND;
                LAND:     if (land_cnt_q == LAND_LAST) state_d = IDLE;
                default:  state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        // NOTE: every target gets its hold value first so no path infers a latch.
        x_d        = x_q;
        y_d        = y_q;
        vx_d       = vx_q;
        vy_d       = vy_q;
        charge_d   = charge_q;
        facing_d   = facing_q;
        landed_d   = 1'b0;
        land_cnt_d = land_cnt_q;
        if (bus.frame_tick) begin
            case (state_q)
                IDLE, WALK: begin
                    if (bus.jump) begin
                        charge_d = '0;
                    end else if (one_dir) begin
                        facing_d = bus.right;
                        x_d      = x_next;
                    end
                end
                CHARGE: begin
                    if (bus.jump) begin
                        if (charge_q < CHG_MAX) charge_d = charge_q + 1'b1;
                        if (one_dir) facing_d = bus.right;
                    end else begin
                        vy_d = launch_vy;
                        vx_d = !one_dir ? '0 : (bus.left ? -AIR_V : AIR_V);
                    end
                end
                AIRBORNE: begin
                    x_d = x_next;
                    if (x_hit_lo || x_hit_hi) begin
`ifdef WALL_BOUNCE_EN
                        vx_d = -vx_q;
`else
                        vx_d = '0;
`endif
                    end
                    if (floor_hit) begin
                        y_d        = POS_W'(FLOOR_Y);
                        vy_d       = '0;
                        vx_d       = '0;
                        charge_d   = '0;
                        landed_d   = 1'b1;
                        land_cnt_d = '0;
                    end else if (y_hit_lo) begin
                        y_d  = y_next;
                        vy_d = '0;
                    end else begin
                        y_d  = y_next;
                        vy_d = (vy_inc > FALL_V) ? FALL_V : vy_inc;
                    end
                end
                LAND: if (land_cnt_q != LAND_LAST) land_cnt_d = land_cnt_q + 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.pos_x  = x_q;
    assign bus.pos_y  = y_q;
    assign bus.state  = state_q;
    assign bus.facing = facing_q;
    assign bus.charge = charge_q;
    assign bus.landed = landed_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Self-checking bench for player_motion_ctrl: vector table, spec sequences, random vs. model.
module tb_player_motion_ctrl;
    import player_pkg::*;

`ifdef WALL_BOUNCE_EN
    localparam bit BOUNCE = 1'b1;
`else
    localparam bit BOUNCE = 1'b0;
`endif

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    always #5 sys_clk = ~sys_clk;

    player_motion_if bus ();

    player_motion_ctrl dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus.slave)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state, plain integers.
    int     m_x, m_y, m_vx, m_vy, m_chg, m_land;
    bit     m_face, m_landed;
    state_e m_st;

    function automatic int clampi(int v, int lo, int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    function automatic void model_reset();
        m_x = 304; m_y = 416; m_vx = 0; m_vy = 0; m_chg = 0; m_land = 0;
        m_face = 1'b1; m_landed = 1'b0; m_st = IDLE;
    endfunction

    function automatic void model_tick(bit l, bit r, bit j);
        int nx, ny;
        m_landed = 1'b0;
        case (m_st)
            IDLE, WALK: begin
                if (j) begin
                    m_st = CHARGE; m_chg = 0;
                end else if (l != r) begin
                    m_st = WALK; m_face = r;
                    m_x = clampi(m_x + (r ? 2 : -2), 0, 608);
                end else begin
                    m_st = IDLE;
                end
            end
            CHARGE: begin
                if (j) begin
                    m_chg = (m_chg + 1 > 20) ? 20 : m_chg + 1;
                    if (l != r) m_face = r;
                end else begin
                    m_st = AIRBORNE;
                    m_vy = -(4 + m_chg);
                    m_vx = (l && !r) ? -3 : (r && !l) ? 3 : 0;
                end
            end
            AIRBORNE: begin
                nx = m_x + m_vx;
                if (nx < 0 || nx > 608) begin
                    m_x  = clampi(nx, 0, 608);
                    m_vx = BOUNCE ? -m_vx : 0;
                end else begin
                    m_x = nx;
                end
                ny = m_y + m_vy;
                if (ny < 0) begin
                    m_y = 0; m_vy = 0;
                end else if (m_vy > 0 && ny >= 416) begin
                    m_y = 416; m_vy = 0; m_vx = 0; m_chg = 0;
                    m_st = LAND; m_land = 0; m_landed = 1'b1;
                end else begin
                    m_y = ny; m_vy = (m_vy + 1 > 12) ? 12 : m_vy + 1;
                end
            end
            LAND: begin
                m_land++;
                if (m_land == 4) m_st = IDLE;
            end
            default: m_st = IDLE;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".x"},      bus.pos_x,  m_x);
        check({tag, ".y"},      bus.pos_y,  m_y);
        check({tag, ".state"},  bus.state,  m_st);
        check({tag, ".facing"}, bus.facing, m_face);
        check({tag, ".charge"}, bus.charge, m_chg);
        check({tag, ".landed"}, bus.landed, m_landed);
    endtask

    // One frame: tick high for one cycle, then sample on the following negedge.
    task automatic step(input bit l, input bit r, input bit j);
        @(negedge sys_clk);
        bus.left = l; bus.right = r; bus.jump = j; bus.frame_tick = 1'b1;
        @(negedge sys_clk);
        bus.frame_tick = 1'b0;
        model_tick(l, r, j);
        check_model("model");
    endtask

    task automatic do_reset(input bit l, input bit r, input bit j);
        @(negedge sys_clk);
        sys_rst = 1'b1; bus.frame_tick = 1'b1;
        bus.left = l; bus.right = r; bus.jump = j;
        @(negedge sys_clk);
        sys_rst = 1'b0; bus.frame_tick = 1'b0;
        bus.left = 1'b0; bus.right = 1'b0; bus.jump = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit     l, r, j;
        int     x, y;
        state_e st;
        bit     face;
        int     chg;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  min_y, land_at, max_x;
        bit  rl, rr, rj;
        int  dir;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 302, 416, WALK,     1'b0, 0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 304, 416, WALK,     1'b1, 0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 304, 416, IDLE,     1'b1, 0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 304, 416, IDLE,     1'b1, 0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 304, 416, CHARGE,   1'b1, 0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 304, 416, CHARGE,   1'b0, 1};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 304, 416, CHARGE,   1'b0, 2};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 304, 416, AIRBORNE, 1'b0, 2};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 304, 410, AIRBORNE, 1'b0, 2};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 304, 405, AIRBORNE, 1'b0, 2};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 304, 401, AIRBORNE, 1'b0, 2};

        bus.frame_tick = 1'b0; bus.left = 1'b0; bus.right = 1'b0; bus.jump = 1'b0;
        repeat (3) @(negedge sys_clk);
        do_reset(1'b0, 1'b0, 1'b0);
        check("reset.x",      bus.pos_x,  304);
        check("reset.y",      bus.pos_y,  416);
        check("reset.state",  bus.state,  IDLE);
        check("reset.facing", bus.facing, 1);
        check("reset.charge", bus.charge, 0);
        check("reset.landed", bus.landed, 0);

        for (int i = 0; i < 11; i++) begin
            step(vecs[i].l, vecs[i].r, vecs[i].j);
            check($sformatf("vec%0d.x", i),      bus.pos_x,  vecs[i].x);
            check($sformatf("vec%0d.y", i),      bus.pos_y,  vecs[i].y);
            check($sformatf("vec%0d.state", i),  bus.state,  vecs[i].st);
            check($sformatf("vec%0d.facing", i), bus.facing, vecs[i].face);
            check($sformatf("vec%0d.charge", i), bus.charge, vecs[i].chg);
        end

        // Reset while airborne, coincident with a frame tick.
        do_reset(1'b1, 1'b0, 1'b1);
        check("midair_rst.x",      bus.pos_x,  304);
        check("midair_rst.y",      bus.pos_y,  416);
        check("midair_rst.state",  bus.state,  IDLE);
        check("midair_rst.charge", bus.charge, 0);
        check("midair_rst.facing", bus.facing, 1);

        repeat (10) step(1'b1, 1'b0, 1'b0);
        check("walk10.x",      bus.pos_x,  284);
        check("walk10.state",  bus.state,  WALK);
        check("walk10.facing", bus.facing, 0);
        step(1'b1, 1'b1, 1'b0);
        check("both_dirs.state", bus.state, IDLE);
        check("both_dirs.x",     bus.pos_x, 284);

        max_x = 0;
        for (int i = 0; i < 200; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (bus.pos_x > max_x) max_x = bus.pos_x;
        end
        check("left_sat.x",       bus.pos_x, 0);
        check("left_sat.no_wrap", (max_x <= 284), 1);

        // Wall hit during a leftward jump from x=4.
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("wall.start_x", bus.pos_x, 4);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        check("wall.launch_x",     bus.pos_x, 4);
        check("wall.launch_state", bus.state, AIRBORNE);
        step(1'b0, 1'b0, 1'b0);
        check("wall.x1", bus.pos_x, 1);
        step(1'b0, 1'b0, 1'b0);
        check("wall.x2", bus.pos_x, 0);
        step(1'b0, 1'b0, 1'b0);
        check("wall.x3", bus.pos_x, BOUNCE ? 3 : 0);
        step(1'b0, 1'b0, 1'b0);
        check("wall.x4", bus.pos_x, BOUNCE ? 6 : 0);
        repeat (5) step(1'b0, 1'b0, 1'b0);
        check("wall.landed", bus.landed, 1);
        check("wall.land_state", bus.state, LAND);
        repeat (4) step(1'b0, 1'b0, 1'b0);
        check("wall.idle", bus.state, IDLE);

        // Charged jump: 5 ticks of jump, then release.
        repeat (5) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check("jump.charge", bus.charge, 4);
        check("jump.state",  bus.state,  AIRBORNE);
        min_y = 416; land_at = 0;
        for (int k = 1; k <= 40 && land_at == 0; k++) begin
            step(1'b0, 1'b0, 1'b0);
            if (bus.pos_y < min_y) min_y = bus.pos_y;
            if (bus.landed) land_at = k;
        end
        check("jump.land_tick",  land_at,    17);
        check("jump.peak_y",     min_y,      380);
        check("jump.land_y",     bus.pos_y,  416);
        check("jump.land_state", bus.state,  LAND);
        @(negedge sys_clk);
        check("jump.landed_width", bus.landed, 0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        check("jump.land_hold", bus.state, LAND);
        step(1'b0, 1'b0, 1'b0);
        check("jump.land_done", bus.state, IDLE);

        repeat (40) step(1'b0, 1'b0, 1'b1);
        check("charge_sat", bus.charge, 20);

        // Random traffic, left-biased then right-biased so both walls get hit.
        rl = 1'b0; rr = 1'b0; rj = 1'b1;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 900; i++) begin
                if ($urandom_range(0, 7) == 0) rj = ~rj;
                dir = $urandom_range(0, 9);
                rl = (p == 0) ? (dir < 6) : (dir < 2);
                rr = (p == 0) ? (dir >= 8) : (dir >= 5);
                if (dir == 9) begin rl = 1'b1; rr = 1'b1; end
                if ($urandom_range(0, 299) == 0) begin
                    do_reset(rl, rr, rj);
                    check_model("rand_rst");
                end else begin
                    step(rl, rr, rj);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
